// File: rtl/cu_command_arbiter_rr.sv
// cu_command_arbiter_rr: round-robin arbiter that shares one AFU command slot
// between the CU command sources (0 vertex ctrl, 1 edge read, 2 edge write,
// 3 prefetch). It limits outstanding commands with a credit counter that is
// refilled by returned responses. The output is one registered stage.
// Optional macro CU_ARB_PERF_COUNTERS_EN adds grant/stall/credit-block counters.
//
// Handshake: a source transfers when req_valid[i] & req_ready[i] are both high
// in the same cycle. The source holds req_cmd slice i stable until that transfer.
// On the output side, cmd_out is consumed when cmd_out_valid & cmd_out_ready are
// both high. cmd_out and cmd_out_id stay stable while cmd_out_valid is high and
// cmd_out_ready is low.
module cu_command_arbiter_rr #(
  parameter int NUM_REQUESTERS = 4,
  parameter int CMD_WIDTH      = 128,
  parameter int MAX_CREDITS    = 64,
  parameter int CREDIT_BITS    = $clog2(MAX_CREDITS) + 1
) (
  input  logic                                clock,
  input  logic                                rstn,
  input  logic                                enabled_in,
  input  logic [NUM_REQUESTERS-1:0]           req_valid,
  input  logic [NUM_REQUESTERS*CMD_WIDTH-1:0] req_cmd,
  output logic [NUM_REQUESTERS-1:0]           req_ready,
  output logic                                cmd_out_valid,
  output logic [CMD_WIDTH-1:0]                cmd_out,
  output logic [$clog2(NUM_REQUESTERS)-1:0]   cmd_out_id,
  input  logic                                cmd_out_ready,
  input  logic                                rsp_valid,
  output logic [CREDIT_BITS-1:0]              credits_avail,
  output logic                                credit_error,
  output logic [1:0]                          dbg_state
`ifdef CU_ARB_PERF_COUNTERS_EN
  ,
  output logic [NUM_REQUESTERS*32-1:0]        grant_count,
  output logic [31:0]                         stall_cycles,
  output logic [31:0]                         credit_block_cycles
`endif
);

  localparam int IDW = $clog2(NUM_REQUESTERS);
  localparam logic [CREDIT_BITS-1:0] MAXC = CREDIT_BITS'(MAX_CREDITS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARB   = 2'd1,
    S_STALL = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   r_valid;
  logic [CMD_WIDTH-1:0]   r_cmd;
  logic [IDW-1:0]         r_id;
  logic [IDW-1:0]         r_ptr;
  logic [CREDIT_BITS-1:0] r_credits;
  logic                   r_err;

  logic                   w_slot_free;
  logic                   w_drain;
  logic                   w_sel_found;
  logic                   w_grant;
  logic [IDW-1:0]         w_sel;
  logic [IDW-1:0]         w_idx;
  logic [IDW-1:0]         w_ptr_next;

  // The slot can take a new command if it is empty or drains this cycle.
  assign w_slot_free = !r_valid || cmd_out_ready;
  assign w_drain     = r_valid && cmd_out_ready;

  // STALL with cmd_out_ready high is the release cycle. The freed slot is refilled there without a bubble.
  assign w_grant = (r_state != S_IDLE) && enabled_in && (r_credits != '0) &&
                   w_slot_free && w_sel_found;

  assign w_ptr_next = (w_sel == IDW'(NUM_REQUESTERS - 1)) ? '0 : w_sel + IDW'(1);

  // Pick the first valid source at or after the pointer, wrapping around.
  always_comb begin
    w_sel       = '0;
    w_idx       = '0;
    w_sel_found = 1'b0;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      w_idx = IDW'((int'(r_ptr) + k) % NUM_REQUESTERS);
      if (!w_sel_found && req_valid[w_idx]) begin
        w_sel       = w_idx;
        w_sel_found = 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (enabled_in) w_next_state = S_ARB;
      S_ARB: begin
        if (r_valid && !cmd_out_ready) w_next_state = S_STALL;
        else if (!enabled_in)          w_next_state = S_IDLE;
      end
      S_STALL: if (cmd_out_ready) w_next_state = enabled_in ? S_ARB : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM outputs: one-hot accept for the selected source only when granting.
  always_comb begin
    req_ready = w_grant ? (NUM_REQUESTERS'(1) << w_sel) : '0;
    dbg_state = r_state;
  end

  // Output stage and round-robin pointer. A drain with no new grant empties the slot.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_valid <= 1'b0;
      r_cmd   <= '0;
      r_id    <= '0;
      r_ptr   <= '0;
    end else if (w_grant) begin
      r_valid <= 1'b1;
      r_cmd   <= req_cmd[w_sel*CMD_WIDTH +: CMD_WIDTH];
      r_id    <= w_sel;
      r_ptr   <= w_ptr_next;
    end else if (w_drain) begin
      r_valid <= 1'b0;
    end
  end

  // Credit counter. A response with nothing outstanding is flagged and does not change the count.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_credits <= MAXC;
      r_err     <= 1'b0;
    end else if (w_grant && !rsp_valid) begin
      r_credits <= r_credits - CREDIT_BITS'(1);
    end else if (!w_grant && rsp_valid) begin
      if (r_credits == MAXC) r_err     <= 1'b1;
      else                   r_credits <= r_credits + CREDIT_BITS'(1);
    end
  end

  assign cmd_out_valid = r_valid;
  assign cmd_out       = r_cmd;
  assign cmd_out_id    = r_id;
  assign credits_avail = r_credits;
  assign credit_error  = r_err;

`ifdef CU_ARB_PERF_COUNTERS_EN
  logic [NUM_REQUESTERS*32-1:0] r_grant_count;
  logic [31:0]                  r_stall_cycles;
  logic [31:0]                  r_credit_block_cycles;

  // Performance counters, free-running and wrapping at 2^32.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_grant_count         <= '0;
      r_stall_cycles        <= '0;
      r_credit_block_cycles <= '0;
    end else begin
      for (int i = 0; i < NUM_REQUESTERS; i++) begin
        if (w_grant && (w_sel == IDW'(i)))
          r_grant_count[i*32 +: 32] <= r_grant_count[i*32 +: 32] + 32'd1;
      end
      if (r_state == S_STALL)
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if ((r_state == S_ARB) && (|req_valid) && (r_credits == '0))
        r_credit_block_cycles <= r_credit_block_cycles + 32'd1;
    end
  end

  assign grant_count         = r_grant_count;
  assign stall_cycles        = r_stall_cycles;
  assign credit_block_cycles = r_credit_block_cycles;
`endif

endmodule

// File: tb/tb_cu_command_arbiter_rr.sv
// tb_cu_command_arbiter_rr: directed bench for cu_command_arbiter_rr.
// The stimulus pushes the hand-computed expected {id, payload} for each grant.
// A negedge monitor pops one entry on every output transfer and compares it.
module tb_cu_command_arbiter_rr;

  localparam int N    = 4;
  localparam int W    = 128;
  localparam int CB   = 7;
  localparam int IDW  = 2;
  localparam int EW   = IDW + W;

  logic           clock = 1'b0;
  logic           rstn;
  logic           enabled_in;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_cmd;
  logic [N-1:0]   req_ready;
  logic           cmd_out_valid;
  logic [W-1:0]   cmd_out;
  logic [IDW-1:0] cmd_out_id;
  logic           cmd_out_ready;
  logic           rsp_valid;
  logic [CB-1:0]  credits_avail;
  logic           credit_error;
  logic [1:0]     dbg_state;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] phase;
  logic [EW-1:0] exp_q[$];

  cu_command_arbiter_rr #(
    .NUM_REQUESTERS(N),
    .CMD_WIDTH(W),
    .MAX_CREDITS(64)
  ) dut (
    .clock(clock),
    .rstn(rstn),
    .enabled_in(enabled_in),
    .req_valid(req_valid),
    .req_cmd(req_cmd),
    .req_ready(req_ready),
    .cmd_out_valid(cmd_out_valid),
    .cmd_out(cmd_out),
    .cmd_out_id(cmd_out_id),
    .cmd_out_ready(cmd_out_ready),
    .rsp_valid(rsp_valid),
    .credits_avail(credits_avail),
    .credit_error(credit_error),
    .dbg_state(dbg_state)
  );

  // Clock and reset block.
  always #5 clock = ~clock;

  function automatic logic [W-1:0] pay(input int i, input logic [31:0] ph);
    return {ph, 32'(i), 32'hC0DE_0000 ^ ph, ~ph ^ 32'(i)};
  endfunction

  // Driver tasks.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_cmds();
    for (int i = 0; i < N; i++) req_cmd[i*W +: W] = pay(i, phase);
  endtask

  task automatic push(input int i);
    exp_q.push_back({IDW'(i), pay(i, phase)});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every output transfer must match the next expected entry.
  always @(negedge clock) begin
    logic [EW-1:0] e;
    if (rstn === 1'b1 && cmd_out_valid === 1'b1 && cmd_out_ready === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL out_unexpected: got id=%0d cmd=%0h expected none", cmd_out_id, cmd_out);
      end else begin
        e = exp_q.pop_front();
        if ({cmd_out_id, cmd_out} !== e) begin
          bad++;
          $display("FAIL out_cmd: got %0h expected %0h", {cmd_out_id, cmd_out}, e);
        end
      end
    end
  end

  initial begin
    rstn          = 1'b0;
    enabled_in    = 1'b0;
    req_valid     = '0;
    req_cmd       = '0;
    cmd_out_ready = 1'b1;
    rsp_valid     = 1'b0;
    phase         = 32'd1;
    set_cmds();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", cmd_out_valid, 0);
    chk("rst_id", cmd_out_id, 0);
    chk_w("rst_cmd", cmd_out, '0);
    chk("rst_credits", credits_avail, 64);
    chk("rst_err", credit_error, 0);
    chk("rst_state", dbg_state, 0);
    rstn = 1'b1;
    tick();
    chk("idle_ready", req_ready, 0);

    // All four sources valid: 0,1,2,3,0,... one per cycle.
    enabled_in = 1'b1;
    req_valid  = 4'b1111;
    tick();
    for (int k = 0; k < 8; k++) begin
      chk("t1_ready", req_ready, 32'(1) << (k % 4));
      chk("t1_credits", credits_avail, 32'(64 - k));
      chk("t1_valid", cmd_out_valid, (k != 0) ? 1 : 0);
      push(k % 4);
      tick();
    end
    req_valid = '0;

    // Wrap search with pointer at 0, then from 3 wrapping to 0.
    phase = 32'd2;
    set_cmds();
    req_valid = 4'b0100;
    #1;
    chk("t2_ready_2", req_ready, 32'b0100);
    chk("t2_credits", credits_avail, 56);
    push(2);
    tick();
    req_valid = 4'b0101;
    #1;
    chk("t2_ready_wrap0", req_ready, 32'b0001);
    push(0);
    tick();
    chk("t2_ready_2b", req_ready, 32'b0100);
    push(2);
    tick();
    req_valid = '0;
    tick();
    chk("t2_credits_end", credits_avail, 53);

    // Stall: output held while cmd_out_ready is low.
    phase = 32'd3;
    set_cmds();
    cmd_out_ready = 1'b0;
    req_valid     = 4'b0010;
    #1;
    chk("t3_ready_1", req_ready, 32'b0010);
    push(1);
    tick();
    req_valid = 4'b1111;
    #1;
    chk("t3_full_ready", req_ready, 0);
    chk("t3_state_arb", dbg_state, 1);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("t3_state_stall", dbg_state, 2);
      chk("t3_stall_ready", req_ready, 0);
      chk("t3_hold_id", cmd_out_id, 1);
      chk_w("t3_hold_cmd", cmd_out, pay(1, 32'd3));
      tick();
    end
    cmd_out_ready = 1'b1;
    #1;
    chk("t3_release_grant", req_ready, 32'b0100);
    push(2);
    tick();
    req_valid = '0;
    chk("t3_state_back", dbg_state, 1);
    chk("t3_credits", credits_avail, 51);
    tick();

    // Credit exhaustion and refill.
    phase = 32'd4;
    set_cmds();
    req_valid = 4'b1000;
    for (int k = 0; k < 51; k++) begin
      #1;
      chk("t4_credits", credits_avail, 32'(51 - k));
      chk("t4_ready", req_ready, 32'b1000);
      push(3);
      tick();
    end
    #1;
    chk("t4_zero_credits", credits_avail, 0);
    chk("t4_zero_ready", req_ready, 0);
    rsp_valid = 1'b1;
    #1;
    chk("t4_rsp_no_grant", req_ready, 0);
    tick();
    rsp_valid = 1'b0;
    #1;
    chk("t4_one_credit", credits_avail, 1);
    chk("t4_refill_grant", req_ready, 32'b1000);
    push(3);
    tick();
    chk("t4_back_zero", credits_avail, 0);
    chk("t4_back_zero_ready", req_ready, 0);
    rsp_valid = 1'b1;
    tick();
    chk("t4_simul_ready", req_ready, 32'b1000);
    push(3);
    tick();
    rsp_valid = 1'b0;
    req_valid = '0;
    chk("t4_simul_credits", credits_avail, 1);
    tick();

    // Response with all credits free raises a sticky error.
    chk("t5_err_clear", credit_error, 0);
    rsp_valid = 1'b1;
    repeat (63) tick();
    chk("t5_full", credits_avail, 64);
    chk("t5_err_still_clear", credit_error, 0);
    tick();
    rsp_valid = 1'b0;
    chk("t5_err_set", credit_error, 1);
    chk("t5_credits_hold", credits_avail, 64);
    tick();
    chk("t5_err_sticky", credit_error, 1);
    chk("t5_credits_sticky", credits_avail, 64);

    // Asynchronous reset with a held command and 10 credits left.
    phase = 32'd6;
    set_cmds();
    req_valid = 4'b0001;
    for (int k = 0; k < 54; k++) begin
      if (k < 53) push(0);
      tick();
    end
    cmd_out_ready = 1'b0;
    req_valid     = '0;
    chk("t6_pre_credits", credits_avail, 10);
    chk("t6_pre_valid", cmd_out_valid, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("t6_async_valid", cmd_out_valid, 0);
    chk("t6_async_credits", credits_avail, 64);
    chk("t6_async_err", credit_error, 0);
    chk("t6_async_state", dbg_state, 0);
    chk("t6_async_id", cmd_out_id, 0);
    chk_w("t6_async_cmd", cmd_out, '0);
    tick();
    rstn          = 1'b1;
    cmd_out_ready = 1'b1;
    tick();
    chk("queue_drained", exp_q.size(), 0);

    // Final report.
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
